// File: rtl/reg32_serial_tx.sv
// reg32_serial_tx: valid/ready loaded parallel-in/serial-out transmitter with tx_valid framing and done pulse.
// Define REG32_TX_PARITY_EN to append an even-parity bit after the last data bit.
module reg32_serial_tx #(
   parameter int WIDTH     = 32,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] D,
   output logic             tx_bit,
   output logic             tx_bit_comp,
   output logic             tx_valid,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
`ifdef REG32_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
   logic par_q, par_d;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tx_bit_q, tx_bit_d, tx_valid_q, tx_valid_d;
   logic             busy_q, busy_d, done_q, done_d, load_ready_q, load_ready_d;

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      cnt_d        = cnt_q;
      tx_bit_d     = 1'b0;
      tx_valid_d   = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      load_ready_d = 1'b0;
`ifdef REG32_TX_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: begin
            load_ready_d = 1'b1;
            if (load_valid) begin
               state_d      = SHIFT;
               sr_d         = D;
               cnt_d        = '0;
               tx_bit_d     = LSB_FIRST ? D[0] : D[WIDTH-1];
               tx_valid_d   = 1'b1;
               busy_d       = 1'b1;
               load_ready_d = 1'b0;
`ifdef REG32_TX_PARITY_EN
               par_d        = ^D;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef REG32_TX_PARITY_EN
               state_d    = PARITY;
               tx_bit_d   = par_q;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
`else
               state_d    = DONE;
               done_d     = 1'b1;
`endif
            end else begin
               // tx_bit already shows the head of sr_q, so the next bit is one position in
               sr_d       = LSB_FIRST ? sr_q >> 1 : sr_q << 1;
               cnt_d      = cnt_q + 1'b1;
               tx_bit_d   = LSB_FIRST ? sr_q[1] : sr_q[WIDTH-2];
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
`ifdef REG32_TX_PARITY_EN
         PARITY: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
`endif
         DONE: begin
            state_d      = IDLE;
            load_ready_d = 1'b1;
         end
         default: begin
            state_d      = IDLE;
            load_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         tx_bit_q     <= 1'b0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
`ifdef REG32_TX_PARITY_EN
         par_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         cnt_q        <= cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
`ifdef REG32_TX_PARITY_EN
         par_q        <= par_d;
`endif
      end
   end

   assign tx_bit      = tx_bit_q;
   assign tx_bit_comp = ~tx_bit_q;
   assign tx_valid    = tx_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign load_ready  = load_ready_q;
endmodule

// File: tb/tb_reg32_serial_tx.sv
// tb_reg32_serial_tx: drives an LSB-first and an MSB-first transmitter with the same inputs and
// compares every cycle of each frame against expected serial words.
module tb_reg32_serial_tx;
   localparam int W = 32;
`ifdef REG32_TX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif
   logic         clk = 1'b0, rst = 1'b0, load_valid = 1'b0;
   logic [W-1:0] D = '0;
   logic         rdy_l, bit_l, comp_l, val_l, busy_l, done_l;
   logic         rdy_m, bit_m, comp_m, val_m, busy_m, done_m;
   int           checks = 0, failures = 0;

   always #5 clk = ~clk;

   reg32_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l), .D(D),
      .tx_bit(bit_l), .tx_bit_comp(comp_l), .tx_valid(val_l), .busy(busy_l), .done(done_l));
   reg32_serial_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m), .D(D),
      .tx_bit(bit_m), .tx_bit_comp(comp_m), .tx_valid(val_m), .busy(busy_m), .done(done_m));

   typedef struct {
      logic [W-1:0] d;
      logic [W-1:0] ser_l;
      logic [W-1:0] ser_m;
      logic         par;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b t=%0t", name, act[5:0], exp[5:0], $time);
      end
   endtask

   // outputs packed as {tx_valid, busy, load_ready, done, tx_bit, tx_bit_comp}
   task automatic chk_both(input string name, input logic [5:0] exp_l, input logic [5:0] exp_m);
      chk({name, "_lsb"}, {2'b0, val_l, busy_l, rdy_l, done_l, bit_l, comp_l}, {2'b0, exp_l});
      chk({name, "_msb"}, {2'b0, val_m, busy_m, rdy_m, done_m, bit_m, comp_m}, {2'b0, exp_m});
   endtask

   // serial position p carries D[p] when LSB first, D[W-1-p] when MSB first
   function automatic logic [W-1:0] serial(input logic [W-1:0] d, input bit lsb);
      logic [W-1:0] s;
      for (int p = 0; p < W; p++) s[p] = lsb ? d[p] : d[W-1-p];
      return s;
   endfunction

   task automatic run_frame(input logic [W-1:0] d, input logic [W-1:0] el, input logic [W-1:0] em,
                            input logic par, input bit hold, input int poke);
      logic bl, bm;
      load_valid = 1'b1;
      D = d;
      @(negedge clk);
      for (int p = 0; p < FL; p++) begin
         bl = (p < W) ? el[p] : par;
         bm = (p < W) ? em[p] : par;
         chk_both("frame_bit", {4'b1100, bl, ~bl}, {4'b1100, bm, ~bm});
         load_valid = hold || (p == poke);
         D = (p == poke) ? 32'h12345678 : $urandom;
         @(negedge clk);
      end
      chk_both("done_cycle", 6'b000101, 6'b000101);
      load_valid = hold;
      D = d;
      @(negedge clk);
      chk_both("idle_after", 6'b001001, 6'b001001);
   endtask

   initial begin
      logic [W-1:0] d;
      tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      tbl[1] = '{32'h80000801, 32'h80000801, 32'h80100001, 1'b1};
      tbl[2] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'h55555555, 1'b0};
      tbl[3] = '{32'h00000001, 32'h00000001, 32'h80000000, 1'b1};
      tbl[4] = '{32'h0000000F, 32'h0000000F, 32'hF0000000, 1'b0};
      tbl[5] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

      #1 rst = 1'b1;
      #1 chk_both("reset_async", 6'b001001, 6'b001001);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_both("reset_idle", 6'b001001, 6'b001001);

      for (int i = 0; i < 6; i++)
         run_frame(tbl[i].d, tbl[i].ser_l, tbl[i].ser_m, tbl[i].par, 1'b0, -1);

      // load attempt mid-frame must be dropped, not queued
      run_frame(tbl[2].d, tbl[2].ser_l, tbl[2].ser_m, tbl[2].par, 1'b0, 5);
      repeat (2) begin
         @(negedge clk);
         chk_both("no_queued_frame", 6'b001001, 6'b001001);
      end

      repeat (8) begin
         d = $urandom;
         run_frame(d, serial(d, 1'b1), serial(d, 1'b0), ^d, 1'b0, -1);
      end

      // held load_valid: DONE then IDLE between consecutive frames
      for (int k = 0; k < 3; k++)
         run_frame(tbl[4].d, tbl[4].ser_l, tbl[4].ser_m, tbl[4].par, k < 2, -1);

      load_valid = 1'b1;
      D = $urandom;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_both("midframe_reset", 6'b001001, 6'b001001);
      @(negedge clk);
      chk_both("reset_hold", 6'b001001, 6'b001001);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_both("post_reset_no_done", 6'b001001, 6'b001001);
      end
      run_frame(tbl[1].d, tbl[1].ser_l, tbl[1].ser_m, tbl[1].par, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
